// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
//
// Shared definitions for the bit-serial subtractor.
// The FSM state encoding is fixed so that all users of the package agree
// on the values of the state register.
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
//
// One-bit combinational subtractor cell, the mirror image of a full adder.
// It computes A - B - Bi and produces the difference bit and the borrow-out.
//
// Ports:
//   A   minuend bit
//   B   subtrahend bit
//   Bi  borrow-in
//   D   difference bit
//   Bo  borrow-out (set when A < B + Bi)
// -----------------------------------------------------------------------------
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bi,
    output logic D,
    output logic Bo
);

    assign D  = A ^ B ^ Bi;
    assign Bo = (~A & B) | (~A & Bi) | (B & Bi);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor computing D = A - B - Bin, LSB first, one bit per
// clock through a single full-subtractor cell and a registered borrow.
// A start/ready/done handshake frames each operation; Bin/Bout allow several
// passes to be chained into a multi-precision subtraction.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  request, accepted only while ready is high
//   A      minuend, sampled on the accepted start
//   B      subtrahend, sampled on the accepted start
//   Bin    borrow-in, sampled on the accepted start
//   ready  high in IDLE, block can accept a start
//   D      registered difference, valid from done onward
//   Bout   final borrow-out (unsigned A < B + Bin)
//   V      signed overflow of A - B
//   done   one-cycle pulse, D/Bout/V valid
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] aShift_q, aShift_d;
    logic [WIDTH-1:0] bShift_q, bShift_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             borrow_q, borrow_d;
    logic             aMsb_q,   aMsb_d;
    logic             bMsb_q,   bMsb_d;
    logic             bout_q,   bout_d;
    logic             v_q,      v_d;

    logic cellD;
    logic cellBo;

    // The single arithmetic cell works on the current LSBs of the operand
    // shift registers and the borrow carried over from the previous bit.
    full_subtractor u_cell (
        .A  (aShift_q[0]),
        .B  (bShift_q[0]),
        .Bi (borrow_q),
        .D  (cellD),
        .Bo (cellBo)
    );

    // Next-state and output logic. Bout and V are latched on the last SHIFT
    // cycle so they are valid together with done and hold until the next
    // accepted start. The overflow term uses the final difference bit
    // directly, since that is what lands in D[WIDTH-1] on the same edge.
    always_comb begin
        state_d  = state_q;
        aShift_d = aShift_q;
        bShift_d = bShift_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        aMsb_d   = aMsb_q;
        bMsb_d   = bMsb_q;
        bout_d   = bout_q;
        v_d      = v_q;
        ready    = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    aShift_d = A;
                    bShift_d = B;
                    borrow_d = Bin;
                    cnt_d    = '0;
                    aMsb_d   = A[WIDTH-1];
                    bMsb_d   = B[WIDTH-1];
                    bout_d   = 1'b0;
                    v_d      = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                aShift_d = aShift_q >> 1;
                bShift_d = bShift_q >> 1;
                diff_d   = {cellD, diff_q[WIDTH-1:1]};
                borrow_d = cellBo;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    bout_d  = cellBo;
                    v_d     = (aMsb_q != bMsb_q) && (cellD != aMsb_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            aShift_q <= '0;
            bShift_q <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            aMsb_q   <= 1'b0;
            bMsb_q   <= 1'b0;
            bout_q   <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            aShift_q <= aShift_d;
            bShift_q <= bShift_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            aMsb_q   <= aMsb_d;
            bMsb_q   <= bMsb_d;
            bout_q   <= bout_d;
            v_q      <= v_d;
        end
    end

    assign D    = diff_q;
    assign Bout = bout_q;
    assign V    = v_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed and random checks of the bit-serial subtractor at WIDTH = 8.
// Inputs change 1 time unit after a rising edge and outputs are sampled at
// the same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             ready;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             V;
    logic             done;

    int passCount;
    int checkCount;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .ready (ready),
        .D     (D),
        .Bout  (Bout),
        .V     (V),
        .done  (done)
    );

    // Free-running clock with a 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation from IDLE and waits, bounded, for done.
    // lat is the number of edges after the start edge until done is seen,
    // or -1 if done never arrived. Returns while done is still high.
    task automatic runOp(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         output logic [7:0] d, output logic bo, output logic v,
                         output int lat);
        A     = a;
        B     = b;
        Bin   = bin;
        start = 1'b1;
        step();
        start = 1'b0;
        lat   = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (done) begin
                lat = i;
                break;
            end
        end
        d  = D;
        bo = Bout;
        v  = V;
    endtask

    // Reset values while rst is held high.
    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        Bin   = 1'b0;
        step();
        step();
        checkCount++;
        if (ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", ready);
        else passCount++;
        checkCount++;
        if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done);
        else passCount++;
        checkCount++;
        if (D !== 8'h00) $display("[TB] FAIL reset_D: got %h expected 00", D);
        else passCount++;
        checkCount++;
        if (Bout !== 1'b0 || V !== 1'b0)
            $display("[TB] FAIL reset_BoutV: got %b%b expected 00", Bout, V);
        else passCount++;
        rst = 1'b0;
        step();
    endtask

    // 0x05 - 0x03 with latency and ready return.
    task automatic test_basic();
        logic [7:0] d;
        logic       bo, v;
        int         lat;
        runOp(8'h05, 8'h03, 1'b0, d, bo, v, lat);
        checkCount++;
        if (lat != WIDTH) $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, WIDTH);
        else passCount++;
        checkCount++;
        if (d !== 8'h02) $display("[TB] FAIL basic_D: got %h expected 02", d);
        else passCount++;
        checkCount++;
        if (bo !== 1'b0 || v !== 1'b0)
            $display("[TB] FAIL basic_BoutV: got %b%b expected 00", bo, v);
        else passCount++;
        checkCount++;
        if (ready !== 1'b0) $display("[TB] FAIL basic_ready_in_done: got %b expected 0", ready);
        else passCount++;
        step();
        checkCount++;
        if (ready !== 1'b1 || done !== 1'b0)
            $display("[TB] FAIL basic_ready_after: got ready=%b done=%b expected ready=1 done=0", ready, done);
        else passCount++;
    endtask

    // Unsigned borrow and signed overflow cases.
    task automatic test_borrow_overflow();
        logic [7:0] d;
        logic       bo, v;
        int         lat;
        runOp(8'h03, 8'h05, 1'b0, d, bo, v, lat);
        checkCount++;
        if (d !== 8'hFE || bo !== 1'b1 || v !== 1'b0)
            $display("[TB] FAIL borrow_03_05: got D=%h Bout=%b V=%b expected D=fe Bout=1 V=0", d, bo, v);
        else passCount++;
        step();
        runOp(8'h80, 8'h01, 1'b0, d, bo, v, lat);
        checkCount++;
        if (d !== 8'h7F || bo !== 1'b0 || v !== 1'b1)
            $display("[TB] FAIL overflow_80_01: got D=%h Bout=%b V=%b expected D=7f Bout=0 V=1", d, bo, v);
        else passCount++;
        step();
        // Equal operands with no borrow-in give zero.
        runOp(8'h5A, 8'h5A, 1'b0, d, bo, v, lat);
        checkCount++;
        if (d !== 8'h00 || bo !== 1'b0 || v !== 1'b0)
            $display("[TB] FAIL equal_5a: got D=%h Bout=%b V=%b expected D=00 Bout=0 V=0", d, bo, v);
        else passCount++;
        step();
    endtask

    // Borrow-in alone and a chained 16-bit subtraction.
    task automatic test_chain();
        logic [7:0] d;
        logic       bo, v;
        logic       lowBo;
        int         lat;
        runOp(8'h00, 8'h00, 1'b1, d, bo, v, lat);
        checkCount++;
        if (d !== 8'hFF || bo !== 1'b1 || v !== 1'b0)
            $display("[TB] FAIL zero_bin: got D=%h Bout=%b V=%b expected D=ff Bout=1 V=0", d, bo, v);
        else passCount++;
        step();
        // 0x0100 - 0x0001: low byte first, its borrow feeds the high byte.
        runOp(8'h00, 8'h01, 1'b0, d, bo, v, lat);
        lowBo = bo;
        checkCount++;
        if (d !== 8'hFF || bo !== 1'b1)
            $display("[TB] FAIL chain_low: got D=%h Bout=%b expected D=ff Bout=1", d, bo);
        else passCount++;
        step();
        runOp(8'h01, 8'h00, lowBo, d, bo, v, lat);
        checkCount++;
        if (d !== 8'h00 || bo !== 1'b0 || v !== 1'b0)
            $display("[TB] FAIL chain_high: got D=%h Bout=%b V=%b expected D=00 Bout=0 V=0", d, bo, v);
        else passCount++;
        step();
    endtask

    // A start pulse during SHIFT must be dropped without queuing.
    task automatic test_ignore_start();
        int         doneCount;
        logic [7:0] dAtDone;
        dAtDone = 8'hXX;
        doneCount = 0;
        A     = 8'h10;
        B     = 8'h01;
        Bin   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        A     = 8'hAA;
        B     = 8'h55;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) begin
                doneCount++;
                dAtDone = D;
            end
        end
        checkCount++;
        if (doneCount != 1) $display("[TB] FAIL ignore_done_count: got %0d expected 1", doneCount);
        else passCount++;
        checkCount++;
        if (dAtDone !== 8'h0F) $display("[TB] FAIL ignore_D: got %h expected 0f", dAtDone);
        else passCount++;
        checkCount++;
        if (D !== 8'h0F || Bout !== 1'b0 || V !== 1'b0)
            $display("[TB] FAIL ignore_hold: got D=%h Bout=%b V=%b expected D=0f Bout=0 V=0", D, Bout, V);
        else passCount++;
        checkCount++;
        if (ready !== 1'b1) $display("[TB] FAIL ignore_ready: got %b expected 1", ready);
        else passCount++;
    endtask

    // Reset in the middle of SHIFT discards the operation.
    task automatic test_mid_reset();
        logic [7:0] d;
        logic       bo, v;
        int         lat;
        int         sawDone;
        A     = 8'hFF;
        B     = 8'h00;
        Bin   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkCount++;
        if (ready !== 1'b1 || done !== 1'b0)
            $display("[TB] FAIL midreset_ready_done: got ready=%b done=%b expected ready=1 done=0", ready, done);
        else passCount++;
        checkCount++;
        if (D !== 8'h00 || Bout !== 1'b0 || V !== 1'b0)
            $display("[TB] FAIL midreset_outputs: got D=%h Bout=%b V=%b expected all 0", D, Bout, V);
        else passCount++;
        sawDone = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) sawDone++;
        end
        checkCount++;
        if (sawDone != 0) $display("[TB] FAIL midreset_no_done: got %0d pulses expected 0", sawDone);
        else passCount++;
        runOp(8'h09, 8'h04, 1'b0, d, bo, v, lat);
        checkCount++;
        if (lat != WIDTH || d !== 8'h05 || bo !== 1'b0)
            $display("[TB] FAIL midreset_fresh: got lat=%0d D=%h Bout=%b expected lat=%0d D=05 Bout=0", lat, d, bo, WIDTH);
        else passCount++;
        step();
    endtask

    // start held high: one accepted operation every WIDTH+2 cycles.
    task automatic test_back_to_back();
        int pulses;
        int lastAt;
        A      = 8'h20;
        B      = 8'h10;
        Bin    = 1'b0;
        start  = 1'b1;
        pulses = 0;
        lastAt = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (done) begin
                pulses++;
                checkCount++;
                if (D !== 8'h10 || Bout !== 1'b0)
                    $display("[TB] FAIL b2b_result: got D=%h Bout=%b expected D=10 Bout=0", D, Bout);
                else passCount++;
                checkCount++;
                if (pulses == 1 && i != WIDTH + 1)
                    $display("[TB] FAIL b2b_first: got edge %0d expected %0d", i, WIDTH + 1);
                else if (pulses > 1 && i - lastAt != WIDTH + 2)
                    $display("[TB] FAIL b2b_period: got %0d expected %0d", i - lastAt, WIDTH + 2);
                else passCount++;
                lastAt = i;
            end
        end
        start = 1'b0;
        checkCount++;
        if (pulses != 3) $display("[TB] FAIL b2b_count: got %0d expected 3", pulses);
        else passCount++;
        step();
        step();
        step();
    endtask

    // Random sweep against an independent 9-bit arithmetic reference.
    task automatic test_random();
        logic [7:0] a, b, d;
        logic       bin, bo, v;
        logic [8:0] ref9;
        logic       refV;
        int         lat;
        for (int n = 0; n < 1000; n++) begin
            a    = 8'($urandom);
            b    = 8'($urandom);
            bin  = 1'($urandom);
            ref9 = {1'b0, a} - {1'b0, b} - {8'h00, bin};
            refV = (a[7] != b[7]) && (ref9[7] != a[7]);
            runOp(a, b, bin, d, bo, v, lat);
            checkCount++;
            if (lat != WIDTH || d !== ref9[7:0] || bo !== ref9[8] || v !== refV)
                $display("[TB] FAIL random_%0d: A=%h B=%h Bin=%b got lat=%0d D=%h Bout=%b V=%b expected lat=%0d D=%h Bout=%b V=%b",
                         n, a, b, bin, lat, d, bo, v, WIDTH, ref9[7:0], ref9[8], refV);
            else passCount++;
            if (lat < 0) break;
            step();
        end
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        Bin   = 1'b0;
        test_reset();
        test_basic();
        test_borrow_overflow();
        test_chain();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
